// File: rtl/signature_scanner.sv
// Runtime-programmable sliding-window byte signature scanner for ROM load streams.
// Reports sticky per-slot hits, a saturating hit-beat count and the first hit location.
module signature_scanner #(
    parameter int NUM_PATTERNS = 8,
    parameter int MAX_BYTES    = 5,
    parameter int ADDR_W       = 15,
    parameter int COUNT_W      = 4,
    parameter int IDX_W        = $clog2(NUM_PATTERNS),
    parameter int POS_W        = $clog2(MAX_BYTES)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    ena,
    input  logic [ADDR_W-1:0]       addr,
    input  logic [7:0]              data,
    input  logic                    last,
    input  logic                    cfg_we,
    input  logic                    cfg_len_we,
    input  logic [IDX_W-1:0]        cfg_pat,
    input  logic [POS_W-1:0]        cfg_pos,
    input  logic [7:0]              cfg_data,
    output logic                    busy,
    output logic                    done,
    output logic                    hasMatch,
    output logic [NUM_PATTERNS-1:0] match_vec,
    output logic                    match_pulse,
    output logic [IDX_W-1:0]        first_idx,
    output logic [ADDR_W-1:0]       first_addr,
    output logic [COUNT_W-1:0]      match_count
);

    localparam int LEN_W = $clog2(MAX_BYTES + 1);
    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_BYTES);

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } state_t;

    state_t state;

    logic [7:0]        sig  [NUM_PATTERNS][MAX_BYTES];
    logic [LEN_W-1:0]  slen [NUM_PATTERNS];
    logic [7:0]        win  [MAX_BYTES];
    logic [7:0]        nwin [MAX_BYTES];
    logic [LEN_W-1:0]  wcnt;
    logic [LEN_W-1:0]  ncnt;
    logic [ADDR_W-1:0] last_addr;
    logic [ADDR_W-1:0] nxt_addr;
    logic              contig;
    logic [NUM_PATTERNS-1:0] hits;
    logic [IDX_W-1:0]  hit_idx;
    logic              any_hit;
    logic              first_seen;
    logic [LEN_W-1:0]  cfg_len;

    assign nxt_addr = last_addr + ADDR_W'(1);
    assign contig   = (wcnt == '0) || (addr == nxt_addr);
    assign any_hit  = |hits;
    assign hasMatch = |match_vec;
    assign cfg_len  = (cfg_data > 8'(MAX_BYTES)) ? LEN_MAX : cfg_data[LEN_W-1:0];

    // Window after accepting the current byte; index 0 is the newest byte.
    always_comb begin
        nwin[0] = data;
        for (int i = 1; i < MAX_BYTES; i++) begin
            nwin[i] = win[i-1];
        end
        if (!contig) begin
            ncnt = LEN_W'(1);
        end else if (wcnt == LEN_MAX) begin
            ncnt = wcnt;
        end else begin
            ncnt = wcnt + LEN_W'(1);
        end
    end

    // Slot byte j (oldest first) lines up with window entry L-1-j.
    always_comb begin
        for (int p = 0; p < NUM_PATTERNS; p++) begin
            hits[p] = (slen[p] != '0) && (ncnt >= slen[p]);
            for (int j = 0; j < MAX_BYTES; j++) begin
                for (int i = 0; i < MAX_BYTES; i++) begin
                    if (LEN_W'(i + j + 1) == slen[p] && sig[p][j] != nwin[i]) begin
                        hits[p] = 1'b0;
                    end
                end
            end
        end
    end

    always_comb begin
        hit_idx = '0;
        for (int p = NUM_PATTERNS - 1; p >= 0; p--) begin
            if (hits[p]) begin
                hit_idx = IDX_W'(p);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            match_vec   <= '0;
            match_pulse <= 1'b0;
            first_idx   <= '0;
            first_addr  <= '0;
            match_count <= '0;
            first_seen  <= 1'b0;
            wcnt        <= '0;
            last_addr   <= '0;
            for (int i = 0; i < MAX_BYTES; i++) begin
                win[i] <= '0;
            end
            for (int p = 0; p < NUM_PATTERNS; p++) begin
                slen[p] <= '0;
                for (int j = 0; j < MAX_BYTES; j++) begin
                    sig[p][j] <= '0;
                end
            end
        end else begin
            match_pulse <= 1'b0;

            if (state != SCAN && int'(cfg_pat) < NUM_PATTERNS) begin
                if (cfg_we && int'(cfg_pos) < MAX_BYTES) begin
                    sig[cfg_pat][cfg_pos] <= cfg_data;
                end
                if (cfg_len_we) begin
                    slen[cfg_pat] <= cfg_len;
                end
            end

            if (start) begin
                state       <= SCAN;
                busy        <= 1'b1;
                done        <= 1'b0;
                match_vec   <= '0;
                match_count <= '0;
                first_idx   <= '0;
                first_addr  <= '0;
                first_seen  <= 1'b0;
                wcnt        <= '0;
            end else if (state == SCAN && ena) begin
                win       <= nwin;
                wcnt      <= ncnt;
                last_addr <= addr;
                if (any_hit) begin
                    match_pulse <= 1'b1;
                    match_vec   <= match_vec | hits;
                    if (match_count != '1) begin
                        match_count <= match_count + COUNT_W'(1);
                    end
                    if (!first_seen) begin
                        first_seen <= 1'b1;
                        first_idx  <= hit_idx;
                        first_addr <= addr;
                    end
                end
                if (last) begin
                    state <= DONE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_signature_scanner.sv
// Directed-vector bench for signature_scanner with immediate-assertion checks.
module tb_signature_scanner;

    logic        clk;
    logic        reset;
    logic        start;
    logic        ena;
    logic [14:0] addr;
    logic [7:0]  data;
    logic        last;
    logic        cfg_we;
    logic        cfg_len_we;
    logic [2:0]  cfg_pat;
    logic [2:0]  cfg_pos;
    logic [7:0]  cfg_data;
    logic        busy;
    logic        done;
    logic        hasMatch;
    logic [7:0]  match_vec;
    logic        match_pulse;
    logic [2:0]  first_idx;
    logic [14:0] first_addr;
    logic [3:0]  match_count;

    int passed = 0;
    int total  = 0;

    signature_scanner dut (
        .clk(clk), .reset(reset), .start(start), .ena(ena),
        .addr(addr), .data(data), .last(last),
        .cfg_we(cfg_we), .cfg_len_we(cfg_len_we), .cfg_pat(cfg_pat),
        .cfg_pos(cfg_pos), .cfg_data(cfg_data),
        .busy(busy), .done(done), .hasMatch(hasMatch),
        .match_vec(match_vec), .match_pulse(match_pulse),
        .first_idx(first_idx), .first_addr(first_addr),
        .match_count(match_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_byte(input int pat, input int pos, input logic [7:0] val);
        cfg_we   = 1'b1;
        cfg_pat  = 3'(pat);
        cfg_pos  = 3'(pos);
        cfg_data = val;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic wr_len(input int pat, input logic [7:0] len);
        cfg_len_we = 1'b1;
        cfg_pat    = 3'(pat);
        cfg_data   = len;
        tick();
        cfg_len_we = 1'b0;
    endtask

    task automatic go();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic beat(input logic [14:0] a, input logic [7:0] d, input logic l);
        ena  = 1'b1;
        addr = a;
        data = d;
        last = l;
        tick();
        ena  = 1'b0;
        last = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        start = 1'b0;
        ena = 1'b0;
        addr = '0;
        data = '0;
        last = 1'b0;
        cfg_we = 1'b0;
        cfg_len_we = 1'b0;
        cfg_pat = '0;
        cfg_pos = '0;
        cfg_data = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_vec", 32'(match_vec), 32'h0);
        chk("rst_cnt", 32'(match_count), 32'h0);
        reset = 1'b1;
        tick();

        // basic 3-byte hit inside a longer stream
        wr_byte(0, 0, 8'h8D);
        wr_byte(0, 1, 8'hE0);
        wr_byte(0, 2, 8'h1F);
        wr_len(0, 8'd3);
        go();
        chk("t1_busy", 32'(busy), 32'd1);
        beat(15'h100, 8'hA9, 1'b0);
        beat(15'h101, 8'h8D, 1'b0);
        beat(15'h102, 8'hE0, 1'b0);
        chk("t1_nopulse", 32'(match_pulse), 32'd0);
        beat(15'h103, 8'h1F, 1'b0);
        chk("t1_pulse", 32'(match_pulse), 32'd1);
        chk("t1_vec", 32'(match_vec), 32'h01);
        chk("t1_idx", 32'(first_idx), 32'd0);
        chk("t1_addr", 32'(first_addr), 32'h103);
        beat(15'h104, 8'hEA, 1'b1);
        chk("t1_pulse_off", 32'(match_pulse), 32'd0);
        chk("t1_cnt", 32'(match_count), 32'd1);
        chk("t1_done", 32'(done), 32'd1);
        chk("t1_busy_off", 32'(busy), 32'd0);

        // address gap restarts the window
        go();
        chk("t2_vec_clr", 32'(match_vec), 32'h0);
        chk("t2_addr_clr", 32'(first_addr), 32'h0);
        beat(15'h200, 8'h8D, 1'b0);
        beat(15'h201, 8'hE0, 1'b0);
        beat(15'h300, 8'h1F, 1'b1);
        chk("t2_hasmatch", 32'(hasMatch), 32'd0);
        chk("t2_done", 32'(done), 32'd1);

        // two slots hit on one beat
        wr_len(0, 8'd0);
        wr_byte(2, 0, 8'hE0);
        wr_byte(2, 1, 8'h1F);
        wr_len(2, 8'd2);
        wr_byte(5, 0, 8'h8D);
        wr_byte(5, 1, 8'hE0);
        wr_byte(5, 2, 8'h1F);
        wr_len(5, 8'd3);
        go();
        beat(15'h010, 8'h8D, 1'b0);
        beat(15'h011, 8'hE0, 1'b0);
        beat(15'h012, 8'h1F, 1'b1);
        chk("t3_pulse", 32'(match_pulse), 32'd1);
        chk("t3_vec", 32'(match_vec), 32'h24);
        chk("t3_idx", 32'(first_idx), 32'd2);
        chk("t3_cnt", 32'(match_count), 32'd1);
        chk("t3_done", 32'(done), 32'd1);

        // saturation; slot1 length 9 clamps to 5 over zero bytes
        wr_len(2, 8'd0);
        wr_len(5, 8'd0);
        wr_byte(0, 0, 8'h00);
        wr_byte(0, 1, 8'h00);
        wr_len(0, 8'd2);
        wr_len(1, 8'd9);
        go();
        for (int i = 0; i < 20; i++) begin
            beat(15'(15'h400 + i), 8'h00, i == 19);
        end
        chk("t4_cnt", 32'(match_count), 32'hF);
        chk("t4_vec", 32'(match_vec), 32'h03);
        chk("t4_idx", 32'(first_idx), 32'd0);
        chk("t4_addr", 32'(first_addr), 32'h401);

        // config ignored in SCAN; address wrap is contiguous
        wr_len(1, 8'd0);
        wr_byte(0, 0, 8'h8D);
        wr_byte(0, 1, 8'hE0);
        go();
        cfg_we = 1'b1;
        cfg_len_we = 1'b1;
        cfg_pat = 3'd0;
        cfg_pos = 3'd0;
        cfg_data = 8'h00;
        tick();
        cfg_we = 1'b0;
        cfg_len_we = 1'b0;
        beat(15'h7FFF, 8'h8D, 1'b0);
        beat(15'h0000, 8'hE0, 1'b1);
        chk("t5_pulse", 32'(match_pulse), 32'd1);
        chk("t5_vec", 32'(match_vec), 32'h01);
        chk("t5_addr", 32'(first_addr), 32'h0);

        // async reset mid-scan
        go();
        beat(15'h010, 8'h8D, 1'b0);
        beat(15'h011, 8'hE0, 1'b0);
        chk("t6_prehit", 32'(match_vec), 32'h01);
        #2;
        reset = 1'b0;
        #1;
        chk("t6_busy", 32'(busy), 32'd0);
        chk("t6_vec", 32'(match_vec), 32'h0);
        chk("t6_cnt", 32'(match_count), 32'h0);
        chk("t6_pulse", 32'(match_pulse), 32'd0);
        tick();
        reset = 1'b1;
        tick();
        go();
        beat(15'h020, 8'h8D, 1'b0);
        beat(15'h021, 8'hE0, 1'b1);
        chk("t6_nohit", 32'(hasMatch), 32'd0);
        chk("t6_done", 32'(done), 32'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
